reg_op_sequencer: RTL and testbench
===================================

// Module: reg_op_sequencer
// PURPOSE
//  Command-driven sequencer that sits directly upstream of the 4004 register file.
//  Executes one register-file instruction per accepted command as a read-modify-write:
//    - INC, ISZ, XCH, LD on single registers
//    - FIM, SRC on register pairs
//  Drives the register file's single-write and pair-write ports, and reads its combinational outputs.
//  Returns results (accumulator value, ISZ branch flag, pair value) to the execute stage.
// PARAMETERS
//  WORD_W   4   register/accumulator width; pair width = 2*WORD_W
//  ADDR_W   4   register index width (16 registers)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  cmdValid   in   1         command offered
//  cmdReady   out  1         high only in IDLE; transfer when cmdValid&cmdReady
//  cmdOp      in   3         0 INC, 1 ISZ, 2 XCH, 3 LD, 4 FIM, 5 SRC, 6 ADD*, 7 SUB*
//  cmdReg     in   ADDR_W    register index; for pair ops bit0 is ignored
//  cmdImm     in   2*WORD_W  FIM immediate {even, odd}
//  accIn      in   WORD_W    accumulator value
//  cyIn       in   1         carry/borrow in (ADD/SUB only)
//  doneValid  out  1         one-cycle result pulse
//  accOut     out  WORD_W    new accumulator value (XCH/LD/ADD/SUB); else accIn captured
//  cyOut      out  1         carry out (ADD/SUB); else 0
//  jumpTaken  out  1         ISZ: incremented result != 0; else 0
//  pairOut    out  2*WORD_W  SRC: pair contents; else 0
//  illegalOp  out  1         pulses with doneValid on an unsupported opcode
//  busy       out  1         FSM not in IDLE
//  regWe, regAddr, regDin                      out  1/ADDR_W/WORD_W     single-write port to register file
//  pairWe, pairAddr, pairDin                   out  1/ADDR_W/2*WORD_W   pair-write port to register file
//  regDout, pairDout                           in   WORD_W/2*WORD_W     combinational reads from register file
// BEHAVIOUR
//  FSM: IDLE -> READ -> WRITE -> DONE -> IDLE.
//   - IDLE: cmdReady=1. On handshake, latch op/reg/imm/acc/cy, then go to READ.
//   - READ: drive regAddr=cmdReg and pairAddr={cmdReg[3:1],0}; sample regDout/pairDout at the edge.
//   - WRITE: registered strobe, exactly one cycle:
//       INC/ISZ: regWe, regDin=Rn+1 (mod 2^WORD_W; F->0)
//       XCH:     regWe, regDin=accIn
//       FIM:     pairWe, pairDin=cmdImm
//       LD/SRC/ADD/SUB/illegal: no strobe
//   - DONE: doneValid=1 for one cycle with all results stable; then return to IDLE.
//  Latency and throughput:
//   - Handshake at edge N -> doneValid high in cycle N+3.
//   - Throughput is one command per 4 cycles.
//  Write-port rules:
//   - regWe and pairWe are never high in the same cycle.
//   - Write addresses/data are held stable from READ through WRITE.
//   - pairAddr is always even.
//  Result values:
//   - ISZ: jumpTaken = (Rn+1 != 0). Rn=F gives Rn=0 and jumpTaken=0.
//   - XCH: accOut = old Rn. LD: accOut = Rn, register unchanged.
//   - SRC: pairOut = pairDout sampled in READ.
//   - Result outputs are undefined-free: 0 whenever doneValid=0.
//  Reset (async, any state): FSM -> IDLE.
//   - All outputs 0 except cmdReady=1.
//   - An in-flight op is abandoned. If reset hits during WRITE, the strobe drops immediately with no partial write.
//  cmdValid while busy is ignored (cmdReady=0); the command must be held by the source.
// CONFIGURATION
//  REG_SEQ_ALU_EN defined:
//   - op 6 ADD: {cyOut,accOut} = accIn + Rn + cyIn
//   - op 7 SUB: accOut = accIn + ~Rn + ~cyIn, cyOut = carry (4004 borrow convention)
//   - No register write for either op.
//  REG_SEQ_ALU_EN undefined:
//   - ops 6/7 complete as illegal: illegalOp=1 with doneValid, accOut=accIn, cyOut=0, no write.
// TESTING
//  - Reset mid-WRITE of FIM R2/R3=0xA5 -> no pairWe after rst; R2,R3 stay 0; cmdReady=1.
//  - INC R5 with R5=F -> regWe in WRITE, regDin=0, R5=0; doneValid 3 cycles after handshake.
//  - ISZ R1: R1=E -> R1=F, jumpTaken=1; repeat -> R1=0, jumpTaken=0.
//  - FIM cmdReg=7 cmdImm=0x3C -> pairAddr=6, R6=3, R7=C; then SRC reg 6 -> pairOut=0x3C.
//  - XCH R9 with accIn=7, R9=2 -> accOut=2, R9=7; LD R9 -> accOut=7, no write strobe.
//  - Op 6 with accIn=9, Rn=8, cyIn=1 -> ALU_EN: accOut=2, cyOut=1; without it: illegalOp=1, accOut=9.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
//   Command-driven read-modify-write sequencer sitting in front of the 4004
//   register file. Each accepted command walks IDLE -> READ -> WRITE -> DONE:
//   the register file is read in READ, at most one write strobe fires in
//   WRITE, and a one-cycle result pulse is returned in DONE.
//
//   Build option: define REG_SEQ_ALU_EN to execute ops 6 (ADD) and 7 (SUB);
//   without it those opcodes complete as illegal.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmdValid/cmdReady           command handshake (ready only in IDLE)
//   cmdOp, cmdReg, cmdImm       opcode, register index, FIM immediate {even,odd}
//   accIn, cyIn                 accumulator and carry in
//   doneValid                   one-cycle result strobe
//   accOut, cyOut, jumpTaken,
//   pairOut, illegalOp          results, forced to 0 while doneValid=0
//   busy                        FSM not in IDLE
//   regWe/regAddr/regDin        single-register write port
//   pairWe/pairAddr/pairDin     register-pair write port
//   regDout, pairDout           combinational register-file read data
module reg_op_sequencer #(
    parameter int WORD_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [2:0]            cmdOp,
    input  logic [ADDR_W-1:0]     cmdReg,
    input  logic [2*WORD_W-1:0]   cmdImm,
    input  logic [WORD_W-1:0]     accIn,
    input  logic                  cyIn,
    output logic                  doneValid,
    output logic [WORD_W-1:0]     accOut,
    output logic                  cyOut,
    output logic                  jumpTaken,
    output logic [2*WORD_W-1:0]   pairOut,
    output logic                  illegalOp,
    output logic                  busy,
    output logic                  regWe,
    output logic [ADDR_W-1:0]     regAddr,
    output logic [WORD_W-1:0]     regDin,
    output logic                  pairWe,
    output logic [ADDR_W-1:0]     pairAddr,
    output logic [2*WORD_W-1:0]   pairDin,
    input  logic [WORD_W-1:0]     regDout,
    input  logic [2*WORD_W-1:0]   pairDout
);

    localparam logic [2:0] OP_INC = 3'd0;
    localparam logic [2:0] OP_ISZ = 3'd1;
    localparam logic [2:0] OP_XCH = 3'd2;
    localparam logic [2:0] OP_LD  = 3'd3;
    localparam logic [2:0] OP_FIM = 3'd4;
    localparam logic [2:0] OP_SRC = 3'd5;
`ifdef REG_SEQ_ALU_EN
    localparam logic [2:0] OP_ADD = 3'd6;
    localparam logic [2:0] OP_SUB = 3'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    // latched command
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   reg_q;
    logic [2*WORD_W-1:0] imm_q;
    logic [WORD_W-1:0]   acc_q;
`ifdef REG_SEQ_ALU_EN
    logic                cy_q;
`else
    logic                unused_cy;
    assign unused_cy = cyIn;
`endif

    // write strobes / data and results, captured at the end of READ
    logic                we_q, pwe_q;
    logic [WORD_W-1:0]   din_q;
    logic [WORD_W-1:0]   res_acc;
    logic                res_cy, res_jmp, res_ill;
    logic [2*WORD_W-1:0] res_pair;

    // combinational evaluation of the latched op against the read data
    logic [WORD_W-1:0]   inc_val;
    logic [WORD_W-1:0]   nx_acc, nx_din;
    logic                nx_cy, nx_jmp, nx_ill, nx_we, nx_pwe;
    logic [2*WORD_W-1:0] nx_pair;
`ifdef REG_SEQ_ALU_EN
    logic [WORD_W:0]     sum_add, sum_sub;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmdValid) state_nx = S_READ;
            S_READ:  state_nx = S_WRITE;
            S_WRITE: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        inc_val = regDout + {{(WORD_W-1){1'b0}}, 1'b1};
`ifdef REG_SEQ_ALU_EN
        sum_add = {1'b0, acc_q} + {1'b0, regDout} + {{WORD_W{1'b0}}, cy_q};
        // 4004 subtract: borrow is the inverted carry in both directions
        sum_sub = {1'b0, acc_q} + {1'b0, ~regDout} + {{WORD_W{1'b0}}, ~cy_q};
`endif
        nx_acc  = acc_q;
        nx_cy   = 1'b0;
        nx_jmp  = 1'b0;
        nx_pair = '0;
        nx_ill  = 1'b0;
        nx_we   = 1'b0;
        nx_pwe  = 1'b0;
        nx_din  = '0;
        case (op_q)
            OP_INC: begin
                nx_we  = 1'b1;
                nx_din = inc_val;
            end
            OP_ISZ: begin
                nx_we  = 1'b1;
                nx_din = inc_val;
                nx_jmp = (inc_val != '0);
            end
            OP_XCH: begin
                nx_we  = 1'b1;
                nx_din = acc_q;
                nx_acc = regDout;
            end
            OP_LD:  nx_acc = regDout;
            OP_FIM: nx_pwe = 1'b1;
            OP_SRC: nx_pair = pairDout;
`ifdef REG_SEQ_ALU_EN
            OP_ADD: {nx_cy, nx_acc} = sum_add;
            OP_SUB: {nx_cy, nx_acc} = sum_sub;
`endif
            default: nx_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            reg_q    <= '0;
            imm_q    <= '0;
            acc_q    <= '0;
`ifdef REG_SEQ_ALU_EN
            cy_q     <= 1'b0;
`endif
            we_q     <= 1'b0;
            pwe_q    <= 1'b0;
            din_q    <= '0;
            res_acc  <= '0;
            res_cy   <= 1'b0;
            res_jmp  <= 1'b0;
            res_ill  <= 1'b0;
            res_pair <= '0;
        end else begin
            if (state == S_IDLE && cmdValid) begin
                op_q  <= cmdOp;
                reg_q <= cmdReg;
                imm_q <= cmdImm;
                acc_q <= accIn;
`ifdef REG_SEQ_ALU_EN
                cy_q  <= cyIn;
`endif
            end
            // strobes live for exactly the WRITE cycle
            we_q  <= 1'b0;
            pwe_q <= 1'b0;
            if (state == S_READ) begin
                we_q     <= nx_we;
                pwe_q    <= nx_pwe;
                din_q    <= nx_din;
                res_acc  <= nx_acc;
                res_cy   <= nx_cy;
                res_jmp  <= nx_jmp;
                res_ill  <= nx_ill;
                res_pair <= nx_pair;
            end
        end
    end

    logic active;
    assign active = (state == S_READ) || (state == S_WRITE);

    assign cmdReady  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign doneValid = (state == S_DONE);

    // addresses come straight from the latched index so they are valid for
    // the combinational read in READ and unchanged through WRITE
    assign regAddr  = active ? reg_q : '0;
    assign pairAddr = active ? {reg_q[ADDR_W-1:1], 1'b0} : '0;
    // READ shows the value about to be written; WRITE shows the registered copy
    assign regDin   = (state == S_READ)  ? nx_din :
                      (state == S_WRITE) ? din_q  : '0;
    assign pairDin  = active ? imm_q : '0;
    assign regWe    = we_q;
    assign pairWe   = pwe_q;

    assign accOut    = doneValid ? res_acc  : '0;
    assign cyOut     = doneValid & res_cy;
    assign jumpTaken = doneValid & res_jmp;
    assign pairOut   = doneValid ? res_pair : '0;
    assign illegalOp = doneValid & res_ill;

endmodule

// File: tb/tb_reg_op_sequencer.sv
module tb_reg_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmdValid, cmdReady;
    logic [2:0] cmdOp;
    logic [3:0] cmdReg;
    logic [7:0] cmdImm;
    logic [3:0] accIn;
    logic       cyIn;
    logic       doneValid;
    logic [3:0] accOut;
    logic       cyOut, jumpTaken, illegalOp, busy;
    logic [7:0] pairOut;
    logic       regWe, pairWe;
    logic [3:0] regAddr, regDin, pairAddr, regDout;
    logic [7:0] pairDin, pairDout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_op_sequencer #(.WORD_W(4), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdReg(cmdReg), .cmdImm(cmdImm), .accIn(accIn), .cyIn(cyIn),
        .doneValid(doneValid), .accOut(accOut), .cyOut(cyOut), .jumpTaken(jumpTaken),
        .pairOut(pairOut), .illegalOp(illegalOp), .busy(busy),
        .regWe(regWe), .regAddr(regAddr), .regDin(regDin),
        .pairWe(pairWe), .pairAddr(pairAddr), .pairDin(pairDin),
        .regDout(regDout), .pairDout(pairDout)
    );

    // register file driven by the DUT's write ports, plus a preset port
    logic [3:0] rf [16];
    logic       pre_en = 1'b0;
    logic [3:0] pre_addr = '0, pre_val = '0;

    assign regDout  = rf[regAddr];
    assign pairDout = {rf[pairAddr], rf[{pairAddr[3:1], 1'b1}]};

    always @(posedge clk) begin
        if (pre_en) rf[pre_addr] <= pre_val;
        if (regWe) rf[regAddr] <= regDin;
        if (pairWe) begin
            rf[pairAddr]                <= pairDin[7:4];
            rf[{pairAddr[3:1], 1'b1}]   <= pairDin[3:0];
        end
    end

    // reference register contents and expected results
    logic [3:0] ref_rf [16];
    logic [3:0] e_acc, e_wd;
    logic       e_cy, e_jmp, e_ill;
    logic [7:0] e_pair;
    int         e_we, e_pwe;

    // observations from one command
    int         o_lat, o_we, o_pwe, o_bad;
    logic [3:0] o_wa, o_wd, o_pa, o_acc;
    logic [7:0] o_pd, o_pair;
    logic       o_cy, o_jmp, o_ill;

    task automatic preset(input logic [3:0] a, input logic [3:0] v);
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        @(negedge clk);
        pre_en = 1'b0;
        ref_rf[a] = v;
    endtask

    // plain-arithmetic model of one instruction
    task automatic ref_exec(input int op, input int r, input int imm, input int acc, input int c);
        int rn, pe, s;
        rn = ref_rf[r]; pe = (r / 2) * 2;
        e_acc = 4'(acc); e_cy = 0; e_jmp = 0; e_pair = 0; e_ill = 0;
        e_we = 0; e_pwe = 0; e_wd = 0;
        case (op)
            0, 1: begin
                e_wd = 4'((rn + 1) % 16); ref_rf[r] = e_wd; e_we = 1;
                if (op == 1) e_jmp = (e_wd != 0);
            end
            2: begin e_acc = 4'(rn); ref_rf[r] = 4'(acc); e_we = 1; e_wd = 4'(acc); end
            3: e_acc = 4'(rn);
            4: begin ref_rf[pe] = 4'(imm / 16); ref_rf[pe+1] = 4'(imm % 16); e_pwe = 1; end
            5: e_pair = 8'(ref_rf[pe] * 16 + ref_rf[pe+1]);
            default: begin
`ifdef REG_SEQ_ALU_EN
                if (op == 6) s = acc + rn + c;
                else         s = acc + (15 - rn) + (1 - c);
                e_acc = 4'(s % 16); e_cy = (s >= 16);
`else
                s = 0;
                e_ill = 1;
`endif
            end
        endcase
    endtask

    // issue one command and record what the DUT does; ends on a negedge
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] r, input logic [7:0] imm,
                           input logic [3:0] acc, input logic c);
        int n;
        logic [3:0] d1;
        @(negedge clk);
        cmdValid = 1; cmdOp = op; cmdReg = r; cmdImm = imm; accIn = acc; cyIn = c;
        o_lat = 99; o_we = 0; o_pwe = 0; o_bad = 0;
        o_wa = 0; o_wd = 0; o_pa = 0; o_pd = 0; o_acc = 0; o_pair = 0;
        o_cy = 0; o_jmp = 0; o_ill = 0; d1 = 0;
        n = 0;
        while (!cmdReady && n < 10) begin @(negedge clk); n++; end
        if (!cmdReady) o_lat = 98;
        @(posedge clk);
        @(negedge clk);
        // scramble the bus to prove the command was latched
        cmdValid = 0; cmdOp = 3'($urandom); cmdReg = 4'($urandom);
        cmdImm = 8'($urandom); accIn = 4'($urandom); cyIn = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (regWe)  begin o_we++;  o_wa = regAddr;  o_wd = regDin;  end
            if (pairWe) begin o_pwe++; o_pa = pairAddr; o_pd = pairDin; end
            if (regWe && pairWe) o_bad++;
            if (pairAddr[0]) o_bad++;
            if (i <= 2 && (regAddr !== r || pairAddr !== {r[3:1], 1'b0} || pairDin !== imm)) o_bad++;
            if (i == 1) d1 = regDin;
            if (i == 2 && regDin !== d1) o_bad++;
            if (i <= 3 && (!busy || cmdReady)) o_bad++;
            if (doneValid) begin
                if (o_lat == 99) begin
                    o_lat = i; o_acc = accOut; o_cy = cyOut; o_jmp = jumpTaken;
                    o_pair = pairOut; o_ill = illegalOp;
                end else o_bad++;
            end else if (accOut !== 0 || cyOut !== 0 || jumpTaken !== 0 || pairOut !== 0 || illegalOp !== 0)
                o_bad++;
            if (i >= 4 && o_lat < 98) begin
                if (!cmdReady || busy) o_bad++;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1; cmdValid = 0; cmdOp = 0; cmdReg = 0; cmdImm = 0; accIn = 0; cyIn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (cmdReady !== 1) begin fails++; $display("FAIL reset_ready got %0b exp 1", cmdReady); end
        tests++; if ({busy, doneValid, regWe, pairWe} !== 4'b0) begin fails++; $display("FAIL reset_ctl got %b exp 0000", {busy, doneValid, regWe, pairWe}); end
        tests++; if ({accOut, cyOut, jumpTaken, pairOut, illegalOp} !== 0) begin fails++; $display("FAIL reset_results got %0h exp 0", {accOut, cyOut, jumpTaken, pairOut, illegalOp}); end
        tests++; if ({regAddr, regDin, pairAddr, pairDin} !== 0) begin fails++; $display("FAIL reset_ports got %0h exp 0", {regAddr, regDin, pairAddr, pairDin}); end
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) preset(4'(i), 4'h0);
    endtask

    task automatic test_inc_wrap();
        preset(4'd5, 4'hF);
        run_cmd(3'd0, 4'd5, 8'h00, 4'h0, 1'b0);
        tests++; if (o_lat !== 3) begin fails++; $display("FAIL inc_latency got %0d exp 3", o_lat); end
        tests++; if (o_we !== 1 || o_wa !== 4'd5 || o_wd !== 4'h0) begin fails++; $display("FAIL inc_write got n=%0d a=%0h d=%0h exp n=1 a=5 d=0", o_we, o_wa, o_wd); end
        tests++; if (rf[5] !== 4'h0 || o_pwe !== 0) begin fails++; $display("FAIL inc_reg got %0h pwe=%0d exp 0 pwe=0", rf[5], o_pwe); end
        tests++; if (o_bad !== 0) begin fails++; $display("FAIL inc_protocol got %0d exp 0", o_bad); end
    endtask

    task automatic test_isz();
        preset(4'd1, 4'hE);
        run_cmd(3'd1, 4'd1, 8'h00, 4'h3, 1'b0);
        tests++; if (o_jmp !== 1 || rf[1] !== 4'hF) begin fails++; $display("FAIL isz_e got jmp=%0b r=%0h exp jmp=1 r=f", o_jmp, rf[1]); end
        run_cmd(3'd1, 4'd1, 8'h00, 4'h3, 1'b0);
        tests++; if (o_jmp !== 0 || rf[1] !== 4'h0) begin fails++; $display("FAIL isz_f got jmp=%0b r=%0h exp jmp=0 r=0", o_jmp, rf[1]); end
        tests++; if (o_acc !== 4'h3) begin fails++; $display("FAIL isz_acc got %0h exp 3", o_acc); end
    endtask

    task automatic test_fim_src();
        run_cmd(3'd4, 4'd7, 8'h3C, 4'h0, 1'b0);
        tests++; if (o_pwe !== 1 || o_pa !== 4'd6 || o_pd !== 8'h3C || o_we !== 0) begin fails++; $display("FAIL fim_write got n=%0d a=%0h d=%0h we=%0d exp n=1 a=6 d=3c we=0", o_pwe, o_pa, o_pd, o_we); end
        tests++; if (rf[6] !== 4'h3 || rf[7] !== 4'hC) begin fails++; $display("FAIL fim_regs got %0h%0h exp 3c", rf[6], rf[7]); end
        run_cmd(3'd5, 4'd6, 8'h00, 4'h0, 1'b0);
        tests++; if (o_pair !== 8'h3C || o_we !== 0 || o_pwe !== 0) begin fails++; $display("FAIL src_pair got %0h exp 3c", o_pair); end
    endtask

    task automatic test_xch_ld();
        preset(4'd9, 4'h2);
        run_cmd(3'd2, 4'd9, 8'h00, 4'h7, 1'b0);
        tests++; if (o_acc !== 4'h2 || rf[9] !== 4'h7) begin fails++; $display("FAIL xch got acc=%0h r=%0h exp acc=2 r=7", o_acc, rf[9]); end
        run_cmd(3'd3, 4'd9, 8'h00, 4'h0, 1'b0);
        tests++; if (o_acc !== 4'h7 || o_we !== 0 || o_pwe !== 0 || rf[9] !== 4'h7) begin fails++; $display("FAIL ld got acc=%0h we=%0d r=%0h exp acc=7 we=0 r=7", o_acc, o_we, rf[9]); end
    endtask

    task automatic test_alu_op6();
        preset(4'd4, 4'h8);
        run_cmd(3'd6, 4'd4, 8'h00, 4'h9, 1'b1);
`ifdef REG_SEQ_ALU_EN
        tests++; if (o_acc !== 4'h2 || o_cy !== 1 || o_ill !== 0) begin fails++; $display("FAIL add got acc=%0h cy=%0b ill=%0b exp 2 1 0", o_acc, o_cy, o_ill); end
`else
        tests++; if (o_acc !== 4'h9 || o_cy !== 0 || o_ill !== 1) begin fails++; $display("FAIL op6_illegal got acc=%0h cy=%0b ill=%0b exp 9 0 1", o_acc, o_cy, o_ill); end
`endif
        tests++; if (o_we !== 0 || o_pwe !== 0 || rf[4] !== 4'h8) begin fails++; $display("FAIL op6_nowrite got we=%0d pwe=%0d r=%0h exp 0 0 8", o_we, o_pwe, rf[4]); end
    endtask

    task automatic test_reset_mid_write();
        preset(4'd2, 4'h0);
        preset(4'd3, 4'h0);
        cmdValid = 1; cmdOp = 3'd4; cmdReg = 4'd2; cmdImm = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 0;
        @(negedge clk);
        tests++; if (pairWe !== 1) begin fails++; $display("FAIL rstw_strobe got %0b exp 1", pairWe); end
        rst = 1;
        #1;
        tests++; if (pairWe !== 0 || cmdReady !== 1 || busy !== 0) begin fails++; $display("FAIL rstw_drop got pwe=%0b rdy=%0b busy=%0b exp 0 1 0", pairWe, cmdReady, busy); end
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        tests++; if (rf[2] !== 4'h0 || rf[3] !== 4'h0) begin fails++; $display("FAIL rstw_regs got %0h%0h exp 00", rf[2], rf[3]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int first, last, cnt;
        preset(4'd3, 4'h0);
        first = -1; last = -1; cnt = 0;
        cmdValid = 1; cmdOp = 3'd0; cmdReg = 4'd3; accIn = 0; cyIn = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (doneValid) begin
                cnt++; last = i;
                if (first < 0) first = i;
            end
            if (i == 12) cmdValid = 0;
        end
        tests++; if (cnt !== 3 || first !== 3 || last !== 11) begin fails++; $display("FAIL b2b_spacing got cnt=%0d first=%0d last=%0d exp 3 3 11", cnt, first, last); end
        tests++; if (rf[3] !== 4'h3) begin fails++; $display("FAIL b2b_count got %0h exp 3", rf[3]); end
    endtask

    task automatic test_random();
        int op, r, imm, acc, c, bad_rf;
        for (int i = 0; i < 16; i++) preset(4'(i), 4'($urandom));
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 7); r = $urandom_range(0, 15);
            imm = $urandom_range(0, 255); acc = $urandom_range(0, 15); c = $urandom_range(0, 1);
            run_cmd(3'(op), 4'(r), 8'(imm), 4'(acc), 1'(c));
            ref_exec(op, r, imm, acc, c);
            bad_rf = 0;
            for (int j = 0; j < 16; j++) if (rf[j] !== ref_rf[j]) bad_rf++;
            tests++;
            if (o_lat !== 3 || o_bad !== 0 || o_acc !== e_acc || o_cy !== e_cy || o_jmp !== e_jmp ||
                o_pair !== e_pair || o_ill !== e_ill || o_we !== e_we || o_pwe !== e_pwe ||
                (e_we == 1 && (o_wd !== e_wd || o_wa !== 4'(r))) || bad_rf != 0) begin
                fails++;
                $display("FAIL rand op=%0d r=%0h got lat=%0d bad=%0d acc=%0h cy=%0b j=%0b p=%0h ill=%0b we=%0d pwe=%0d wd=%0h rf_err=%0d exp lat=3 bad=0 acc=%0h cy=%0b j=%0b p=%0h ill=%0b we=%0d pwe=%0d wd=%0h rf_err=0",
                         op, r, o_lat, o_bad, o_acc, o_cy, o_jmp, o_pair, o_ill, o_we, o_pwe, o_wd, bad_rf,
                         e_acc, e_cy, e_jmp, e_pair, e_ill, e_we, e_pwe, e_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_isz();
        test_fim_src();
        test_xch_ld();
        test_alu_op6();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
